alu_issue_arbiter: RTL and testbench
====================================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares one pipelined integer ALU between NrPorts issue requesters (e.g. two issue lanes).
//  Each cycle it picks at most one request by round-robin, drives the ALU operand and valid
//  inputs, and tracks each in-flight op's tag {port, trans_id} through a fixed-latency pipe.
//  It captures the ALU result into a result FIFO that drains to writeback under valid/ready.
//  Credit-based issue guarantees no result is ever lost.
// PARAMETERS
//  CVA6Cfg      config_pkg::cva6_cfg_empty  core configuration (XLEN via riscv::XLEN)
//  NrPorts      2                           number of requesters (>=2)
//  TransIdBits  3                           width of the scoreboard transaction id
//  AluLatency   1                           cycles from alu_valid_o to result on alu_result_i (>=1)
//  FifoDepth    4                           result FIFO entries (>=AluLatency+1)
// PORTS
//  clk_i              in   1                          clock
//  rst_i              in   1                          synchronous reset, active-high
//  flush_i            in   1                          kill all queued and in-flight ops
//  req_valid_i        in   NrPorts                    per-port request valid
//  req_ready_o        out  NrPorts                    per-port grant (one-hot or zero)
//  req_data_i         in   NrPorts x fu_data_t        per-port operation and operands
//  req_trans_id_i     in   NrPorts x TransIdBits      per-port transaction id
//  alu_valid_o        out  1                          op issued to ALU this cycle
//  alu_data_o         out  fu_data_t                  selected op to ALU
//  alu_valid_i        in   1                          ALU registered valid (check only)
//  alu_result_i       in   XLEN                       ALU registered result
//  alu_branch_res_i   in   1                          ALU branch compare result (sampled at issue)
//  res_valid_o        out  1                          FIFO head valid
//  res_ready_i        in   1                          writeback accepts head
//  res_data_o         out  XLEN                       result
//  res_branch_o       out  1                          branch compare bit
//  res_port_o         out  $clog2(NrPorts)            originating port
//  res_trans_id_o     out  TransIdBits                originating transaction id
//  err_o              out  1                          sticky tag/ALU-valid mismatch
// BEHAVIOUR
//  Reset: rr_ptr=0, FIFO empty, tag pipe cleared, inflight=0, err_o=0.
//  During and right after reset, res_valid_o=0, alu_valid_o=0 and req_ready_o=0.
//  Credits: issue_ok = !flush_i && (fifo_count + inflight < FifoDepth).
//  Arbitration: if issue_ok, grant the first port with req_valid_i set, searching from rr_ptr
//  upward and wrapping mod NrPorts. req_ready_o is combinational and asserts only for the granted port.
//  On grant g: alu_valid_o=1, alu_data_o=req_data_i[g], rr_ptr<=(g+1)%NrPorts. With no grant, rr_ptr holds.
//  When alu_valid_o=0, alu_data_o operation is forced to ADD with zero operands.
//  The combinational branch bit is sampled at issue and carried in the tag.
//  Tag pipe: AluLatency stages of {vld, port, trans_id, branch}. Stage 0 loads on issue.
//  inflight counts valid stages.
//  Capture: when the last stage has vld=1, push {alu_result_i, branch, port, trans_id} into the FIFO.
//  The push happens in that cycle.
//  Latency: issue in cycle N means res_valid_o rises in cycle N+AluLatency+1. There is no bypass.
//  FIFO: pop on res_valid_o && res_ready_i. Simultaneous push and pop are allowed at any count,
//  and the count is unchanged. A push when full cannot happen because credits prevent it. If it does, set err_o.
//  Check: alu_valid_i must equal last-stage vld for non-branch ops; any mismatch sets err_o until reset.
//  Branch ops (EQ/NE/LTS/LTU/GES/GEU) are exempt because the ALU does not flag them valid.
//  Flush: in the flush cycle there is no grant, all tag vld bits clear, and the FIFO empties.
//  Any pop presented in that cycle is ignored. The cycle after the flush is fully idle, with credits = FifoDepth.
//  Reset mid-operation: all state returns to its reset values the next cycle. In-flight results are dropped.
// TESTING
//  1) Reset, then a single ADD on port0 with a=5, b=7, trans_id=3 and res_ready_i=1
//     -> req_ready_o=01 in cycle 0; res_valid_o in cycle 2 with data 12, port 0, trans_id 3.
//  2) Both ports valid every cycle, ready=1 -> grants alternate 01,10,01,10.
//     Results arrive in issue order, one per cycle.
//  3) res_ready_i=0 with port0 always valid -> exactly 4 issues, then req_ready_o=0.
//     After one pop, one more issue follows; nothing is lost.
//  4) Issue SUB 3-5 and then flush_i in the next cycle -> no res_valid_o for either op.
//     The cycle after the flush, the FIFO is empty and the next issue is accepted.
//  5) The ALU model drops alu_valid_i for an ADD -> err_o=1 one cycle later and stays 1 until rst_i.
//  6) An EQ branch with a=b=9 -> res_branch_o=1 with the tag intact and err_o unchanged.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
//
// Shares one pipelined integer ALU between NrPorts issue requesters. Each cycle
// at most one request is granted round-robin and driven onto the ALU. A
// fixed-latency tag pipe follows each op. When the op leaves the ALU, its result
// and tag are pushed into a small result FIFO, and writeback drains that FIFO
// under valid/ready. The ALU itself never stalls. No result can be lost because
// issue is credit-limited: queued results plus in-flight ops never exceed
// FifoDepth.
//
// Operation word (per port and on alu_data_o), MSB first:
//   { operation[OpBits-1:0], operand_a[XLEN-1:0], operand_b[XLEN-1:0] }
// Operation codes follow the core's fu_op numbering (ADD=0, SUB=1, LTS=13,
// LTU=14, GES=15, GEU=16, EQ=17, NE=18).
//
// Ports
//   clk_i            clock
//   rst_i            synchronous reset, active-high
//   flush_i          kill all queued and in-flight ops
//   req_valid_i      per-port request valid               [NrPorts]
//   req_ready_o      per-port grant, one-hot or zero      [NrPorts]
//   req_data_i       per-port operation words             [NrPorts*DataW]
//   req_trans_id_i   per-port transaction ids             [NrPorts*TransIdBits]
//   alu_valid_o      op issued to the ALU this cycle
//   alu_data_o       operation word to the ALU (ADD 0,0 when idle)
//   alu_valid_i      ALU registered valid, used only for consistency checking
//   alu_result_i     ALU registered result
//   alu_branch_res_i ALU combinational branch compare, sampled at issue
//   res_valid_o      result FIFO head valid
//   res_ready_i      writeback accepts the head
//   res_data_o       result value
//   res_branch_o     branch compare bit (0 for non-branch ops)
//   res_port_o       originating port
//   res_trans_id_o   originating transaction id
//   err_o            sticky tag / ALU-valid mismatch or FIFO overflow
// -----------------------------------------------------------------------------
module alu_issue_arbiter #(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned NrPorts     = 2,
   parameter int unsigned TransIdBits = 3,
   parameter int unsigned AluLatency  = 1,
   parameter int unsigned FifoDepth   = 4,
   parameter int unsigned OpBits      = 7,
   localparam int unsigned PortW      = $clog2(NrPorts),
   localparam int unsigned DataW      = OpBits + 2 * XLEN
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic [NrPorts-1:0]             req_valid_i,
   output logic [NrPorts-1:0]             req_ready_o,
   input  logic [NrPorts*DataW-1:0]       req_data_i,
   input  logic [NrPorts*TransIdBits-1:0] req_trans_id_i,
   output logic                           alu_valid_o,
   output logic [DataW-1:0]               alu_data_o,
   input  logic                           alu_valid_i,
   input  logic [XLEN-1:0]                alu_result_i,
   input  logic                           alu_branch_res_i,
   output logic                           res_valid_o,
   input  logic                           res_ready_i,
   output logic [XLEN-1:0]                res_data_o,
   output logic                           res_branch_o,
   output logic [PortW-1:0]               res_port_o,
   output logic [TransIdBits-1:0]         res_trans_id_o,
   output logic                           err_o
);

   localparam logic [OpBits-1:0] OP_ADD = OpBits'(0);
   localparam logic [OpBits-1:0] OP_LTS = OpBits'(13);
   localparam logic [OpBits-1:0] OP_LTU = OpBits'(14);
   localparam logic [OpBits-1:0] OP_GES = OpBits'(15);
   localparam logic [OpBits-1:0] OP_GEU = OpBits'(16);
   localparam logic [OpBits-1:0] OP_EQ  = OpBits'(17);
   localparam logic [OpBits-1:0] OP_NE  = OpBits'(18);

   localparam int unsigned CntW = $clog2(FifoDepth + 1);
   localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int unsigned EntW = XLEN + 1 + PortW + TransIdBits;

   // ---------------- request unpacking and grant decode ----------------
   logic [DataW-1:0]       port_data [NrPorts];
   logic [TransIdBits-1:0] port_tid  [NrPorts];
   logic                   grant_vld;
   logic [PortW-1:0]       grant_idx;

   for (genvar gi = 0; gi < NrPorts; gi++) begin : g_port
      assign port_data[gi]   = req_data_i[gi*DataW +: DataW];
      assign port_tid[gi]    = req_trans_id_i[gi*TransIdBits +: TransIdBits];
      assign req_ready_o[gi] = grant_vld && (grant_idx == PortW'(gi));
   end

   // ---------------- credits ----------------
   logic [CntW-1:0] count_reg;
   logic [CntW-1:0] inflight;
   logic            issue_ok;

   // Reset also blocks issue so nothing is granted while state is being cleared.
   assign issue_ok = !rst_i && !flush_i &&
                     (({1'b0, count_reg} + {1'b0, inflight}) < (CntW+1)'(FifoDepth));

   // ---------------- round-robin arbiter ----------------
   logic [PortW-1:0] rr_ptr_reg, rr_ptr_next;
   logic [PortW:0]   cand_idx;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand_idx  = '0;
      for (int k = 0; k < NrPorts; k++) begin
         // Candidate = (rr_ptr + k) mod NrPorts, without a divider.
         cand_idx = {1'b0, rr_ptr_reg} + (PortW+1)'(k);
         if (cand_idx >= (PortW+1)'(NrPorts)) cand_idx = cand_idx - (PortW+1)'(NrPorts);
         if (!grant_vld && req_valid_i[cand_idx[PortW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand_idx[PortW-1:0];
         end
      end
      if (!issue_ok) grant_vld = 1'b0;
   end

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (grant_vld)
         rr_ptr_next = (grant_idx == PortW'(NrPorts - 1)) ? '0 : grant_idx + PortW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) rr_ptr_reg <= '0;
      else       rr_ptr_reg <= rr_ptr_next;
   end

   // ---------------- ALU drive ----------------
   logic [OpBits-1:0] sel_op;
   logic              sel_is_branch;

   assign alu_valid_o   = grant_vld;
   assign alu_data_o    = grant_vld ? port_data[grant_idx] : {OP_ADD, XLEN'(0), XLEN'(0)};
   assign sel_op        = alu_data_o[DataW-1 -: OpBits];
   assign sel_is_branch = grant_vld &&
                          (sel_op inside {OP_EQ, OP_NE, OP_LTS, OP_LTU, OP_GES, OP_GEU});

   // ---------------- tag pipe ----------------
   logic [AluLatency-1:0]                  stage_vld_reg;
   logic [AluLatency-1:0]                  stage_br_reg;
   logic [AluLatency-1:0]                  stage_isbr_reg;
   logic [AluLatency-1:0][PortW-1:0]       stage_port_reg;
   logic [AluLatency-1:0][TransIdBits-1:0] stage_tid_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         stage_vld_reg  <= '0;
         stage_br_reg   <= '0;
         stage_isbr_reg <= '0;
         stage_port_reg <= '0;
         stage_tid_reg  <= '0;
      end else begin
         stage_vld_reg[0]  <= grant_vld;
         // Branch bit is only meaningful for compare ops; masked otherwise.
         stage_br_reg[0]   <= alu_branch_res_i && sel_is_branch;
         stage_isbr_reg[0] <= sel_is_branch;
         stage_port_reg[0] <= grant_idx;
         stage_tid_reg[0]  <= port_tid[grant_idx];
         for (int s = 1; s < AluLatency; s++) begin
            stage_vld_reg[s]  <= stage_vld_reg[s-1];
            stage_br_reg[s]   <= stage_br_reg[s-1];
            stage_isbr_reg[s] <= stage_isbr_reg[s-1];
            stage_port_reg[s] <= stage_port_reg[s-1];
            stage_tid_reg[s]  <= stage_tid_reg[s-1];
         end
      end
   end

   always_comb begin
      inflight = '0;
      for (int s = 0; s < AluLatency; s++) inflight = inflight + CntW'(stage_vld_reg[s]);
   end

   logic last_vld, last_isbr;
   assign last_vld  = stage_vld_reg[AluLatency-1];
   assign last_isbr = stage_isbr_reg[AluLatency-1];

   // ---------------- result FIFO ----------------
   // The head is read combinationally so a result is visible the cycle after
   // its push.
   logic [EntW-1:0] fifo_mem [FifoDepth];
   logic [PtrW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic            push, pop, full, push_ok, overflow;
   logic [EntW-1:0] head;

   assign res_valid_o = (count_reg != '0);
   assign full        = (count_reg == CntW'(FifoDepth));
   assign push        = last_vld && !flush_i;
   assign pop         = res_valid_o && res_ready_i && !flush_i;
   assign push_ok     = push && (!full || pop);
   assign overflow    = push && full && !pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)     rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         unique case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + CntW'(1);
            2'b01:   count_reg <= count_reg - CntW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok)
         fifo_mem[wr_ptr_reg] <= {alu_result_i, stage_br_reg[AluLatency-1],
                                  stage_port_reg[AluLatency-1], stage_tid_reg[AluLatency-1]};
   end

   assign head           = fifo_mem[rd_ptr_reg];
   assign res_data_o     = head[EntW-1 -: XLEN];
   assign res_branch_o   = head[PortW + TransIdBits];
   assign res_port_o     = head[TransIdBits +: PortW];
   assign res_trans_id_o = head[TransIdBits-1:0];

   // ---------------- consistency check ----------------
   // Branch compares never raise the ALU valid, so they are exempt.
   logic chk_mismatch;
   logic err_reg;

   assign chk_mismatch = (alu_valid_i != last_vld) && !(last_vld && last_isbr);

   always_ff @(posedge clk_i) begin
      if (rst_i)                         err_reg <= 1'b0;
      else if (overflow || chk_mismatch) err_reg <= 1'b1;
   end

   assign err_o = err_reg;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_arbiter
//
// Directed bench for alu_issue_arbiter with default parameters. A tiny
// single-cycle ALU model feeds the DUT. Expected values are hand-computed
// constants. One line is printed per delivered result.
// -----------------------------------------------------------------------------
module tb_alu_issue_arbiter;

   localparam int XLEN   = 64;
   localparam int OpBits = 7;
   localparam int DataW  = OpBits + 2 * XLEN;

   localparam logic [6:0] OP_ADD = 7'd0;
   localparam logic [6:0] OP_SUB = 7'd1;
   localparam logic [6:0] OP_EQ  = 7'd17;

   logic             clk;
   logic             rst_i, flush_i;
   logic [1:0]       req_valid_i, req_ready_o;
   logic [2*DataW-1:0] req_data_i;
   logic [5:0]       req_trans_id_i;
   logic             alu_valid_o;
   logic [DataW-1:0] alu_data_o;
   logic             alu_valid_i;
   logic [63:0]      alu_result_i;
   logic             alu_branch_res_i;
   logic             res_valid_o, res_ready_i;
   logic [63:0]      res_data_o;
   logic             res_branch_o;
   logic             res_port_o;
   logic [2:0]       res_trans_id_o;
   logic             err_o;
   logic             drop_valid;

   int n_cmp;
   int n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   alu_issue_arbiter dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .flush_i         (flush_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_data_i      (req_data_i),
      .req_trans_id_i  (req_trans_id_i),
      .alu_valid_o     (alu_valid_o),
      .alu_data_o      (alu_data_o),
      .alu_valid_i     (alu_valid_i),
      .alu_result_i    (alu_result_i),
      .alu_branch_res_i(alu_branch_res_i),
      .res_valid_o     (res_valid_o),
      .res_ready_i     (res_ready_i),
      .res_data_o      (res_data_o),
      .res_branch_o    (res_branch_o),
      .res_port_o      (res_port_o),
      .res_trans_id_o  (res_trans_id_o),
      .err_o           (err_o)
   );

   // ---------------- single-cycle ALU model ----------------
   logic [6:0]  m_op;
   logic [63:0] m_a, m_b;
   logic        m_is_br;

   assign m_op    = alu_data_o[DataW-1 -: 7];
   assign m_a     = alu_data_o[127:64];
   assign m_b     = alu_data_o[63:0];
   assign m_is_br = (m_op >= 7'd13) && (m_op <= 7'd18);

   always_comb begin
      alu_branch_res_i = 1'b0;
      case (m_op)
         7'd13: alu_branch_res_i = $signed(m_a) < $signed(m_b);
         7'd14: alu_branch_res_i = m_a < m_b;
         7'd15: alu_branch_res_i = $signed(m_a) >= $signed(m_b);
         7'd16: alu_branch_res_i = m_a >= m_b;
         7'd17: alu_branch_res_i = m_a == m_b;
         7'd18: alu_branch_res_i = m_a != m_b;
         default: alu_branch_res_i = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         alu_valid_i  <= 1'b0;
         alu_result_i <= '0;
      end else begin
         alu_valid_i  <= alu_valid_o && !m_is_br && !drop_valid;
         alu_result_i <= (m_op == OP_ADD) ? m_a + m_b :
                         (m_op == OP_SUB) ? m_a - m_b : 64'd0;
      end
   end

   // ---------------- helpers ----------------
   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DataW-1:0] mk(input logic [6:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
      return {op, a, b};
   endfunction

   task automatic set_port(input int p, input logic v, input logic [DataW-1:0] d,
                           input logic [2:0] tid);
      req_valid_i[p]             = v;
      req_data_i[p*DataW +: DataW] = d;
      req_trans_id_i[p*3 +: 3]   = tid;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_i       = 1'b1;
      flush_i     = 1'b0;
      req_valid_i = 2'b00;
      res_ready_i = 1'b0;
      drop_valid  = 1'b0;
      next_cycle();
      next_cycle();
      rst_i = 1'b0;
   endtask

   task automatic check_res(input string tag, input logic [63:0] d, input logic br,
                            input logic port, input logic [2:0] tid);
      check_val({tag, ".vld"},  64'(res_valid_o),    64'd1);
      check_val({tag, ".data"}, res_data_o,           d);
      check_val({tag, ".br"},   64'(res_branch_o),    64'(br));
      check_val({tag, ".port"}, 64'(res_port_o),      64'(port));
      check_val({tag, ".tid"},  64'(res_trans_id_o),  64'(tid));
      $display("txn %s: data=%0d br=%0d port=%0d tid=%0d", tag, res_data_o, res_branch_o,
               res_port_o, res_trans_id_o);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected summary");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      n_cmp          = 0;
      n_err          = 0;
      rst_i          = 1'b1;
      flush_i        = 1'b0;
      req_valid_i    = 2'b00;
      req_data_i     = '0;
      req_trans_id_i = '0;
      res_ready_i    = 1'b1;
      drop_valid     = 1'b0;

      // Reset with both ports requesting: nothing may be granted or issued.
      set_port(0, 1'b1, mk(OP_ADD, 64'd1, 64'd1), 3'd0);
      set_port(1, 1'b1, mk(OP_ADD, 64'd2, 64'd2), 3'd1);
      next_cycle();
      sample();
      check_val("rst.ready",   64'(req_ready_o), 64'd0);
      check_val("rst.alu_vld", 64'(alu_valid_o), 64'd0);
      check_val("rst.res_vld", 64'(res_valid_o), 64'd0);
      check_val("rst.err",     64'(err_o),       64'd0);

      // 1) single ADD 5+7 on port 0, tid 3
      do_reset();
      res_ready_i = 1'b1;
      set_port(0, 1'b1, mk(OP_ADD, 64'd5, 64'd7), 3'd3);
      sample();
      check_val("t1.ready",   64'(req_ready_o), 64'd1);
      check_val("t1.alu_vld", 64'(alu_valid_o), 64'd1);
      check_val("t1.alu_op",  64'(alu_data_o[DataW-1 -: 7]), 64'(OP_ADD));
      check_val("t1.alu_a",   alu_data_o[127:64], 64'd5);
      check_val("t1.alu_b",   alu_data_o[63:0],   64'd7);
      check_val("t1.res0",    64'(res_valid_o), 64'd0);
      next_cycle();
      req_valid_i = 2'b00;
      sample();
      check_val("t1.res1",    64'(res_valid_o), 64'd0);
      check_val("t1.idle_vld", 64'(alu_valid_o), 64'd0);
      check_val("t1.idle_op", 64'(alu_data_o[DataW-1 -: 7]), 64'(OP_ADD));
      check_val("t1.idle_a",  alu_data_o[127:64], 64'd0);
      check_val("t1.idle_b",  alu_data_o[63:0],   64'd0);
      next_cycle();
      sample();
      check_res("t1", 64'd12, 1'b0, 1'b0, 3'd3);
      next_cycle();
      sample();
      check_val("t1.res3", 64'(res_valid_o), 64'd0);

      // 2) both ports every cycle: grants alternate, results in issue order
      do_reset();
      res_ready_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c < 4) begin
            set_port(0, 1'b1, mk(OP_ADD, 64'd3, 64'd4), 3'(c));
            set_port(1, 1'b1, mk(OP_SUB, 64'd50, 64'd8), 3'(4 + c));
         end else begin
            req_valid_i = 2'b00;
         end
         sample();
         if (c < 4) check_val("t2.grant", 64'(req_ready_o), (c % 2 == 0) ? 64'd1 : 64'd2);
         if (c >= 2) begin
            if ((c - 2) % 2 == 0) check_res("t2", 64'd7,  1'b0, 1'b0, 3'(c - 2));
            else                  check_res("t2", 64'd42, 1'b0, 1'b1, 3'(4 + c - 2));
         end
         next_cycle();
      end
      sample();
      check_val("t2.end", 64'(res_valid_o), 64'd0);

      // 3) back-pressure: credits stop issue at FifoDepth, one pop frees one slot
      do_reset();
      for (int c = 0; c < 9; c++) begin
         set_port(0, 1'b1, mk(OP_ADD, 64'(c), 64'd100), 3'(c));
         res_ready_i = (c == 6);
         sample();
         check_val("t3.ready", 64'(req_ready_o), (c < 4 || c == 7) ? 64'd1 : 64'd0);
         if (c == 6) check_res("t3.pop", 64'd100, 1'b0, 1'b0, 3'd0);
         next_cycle();
      end
      req_valid_i = 2'b00;
      res_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sample();
         if (k < 3) check_res("t3.drain", 64'(101 + k), 1'b0, 1'b0, 3'(1 + k));
         else       check_res("t3.drain", 64'd107,      1'b0, 1'b0, 3'd7);
         next_cycle();
      end
      sample();
      check_val("t3.end", 64'(res_valid_o), 64'd0);

      // 4) flush kills both a queued result and an in-flight SUB
      do_reset();
      res_ready_i = 1'b0;
      set_port(0, 1'b1, mk(OP_ADD, 64'd1, 64'd2), 3'd1);
      sample();
      check_val("t4.ready0", 64'(req_ready_o), 64'd1);
      next_cycle();
      set_port(0, 1'b1, mk(OP_SUB, 64'd3, 64'd5), 3'd2);
      sample();
      check_val("t4.ready1", 64'(req_ready_o), 64'd1);
      next_cycle();
      flush_i     = 1'b1;
      res_ready_i = 1'b1;
      set_port(0, 1'b1, mk(OP_ADD, 64'd1, 64'd1), 3'd4);
      sample();
      check_val("t4.fl_ready", 64'(req_ready_o), 64'd0);
      check_val("t4.fl_alu",   64'(alu_valid_o), 64'd0);
      check_val("t4.fl_head",  64'(res_valid_o), 64'd1);
      next_cycle();
      flush_i = 1'b0;
      sample();
      check_val("t4.post_ready", 64'(req_ready_o), 64'd1);
      check_val("t4.post_res",   64'(res_valid_o), 64'd0);
      next_cycle();
      req_valid_i = 2'b00;
      sample();
      check_val("t4.no_sub", 64'(res_valid_o), 64'd0);
      next_cycle();
      sample();
      check_res("t4", 64'd2, 1'b0, 1'b0, 3'd4);
      next_cycle();
      sample();
      check_val("t4.end", 64'(res_valid_o), 64'd0);
      check_val("t4.err", 64'(err_o),       64'd0);

      // 6) branch compares: EQ 9,9 on port 1 then EQ 9,8 on port 0
      do_reset();
      res_ready_i = 1'b1;
      set_port(1, 1'b1, mk(OP_EQ, 64'd9, 64'd9), 3'd6);
      sample();
      check_val("t6.ready0", 64'(req_ready_o), 64'd2);
      next_cycle();
      req_valid_i = 2'b00;
      set_port(0, 1'b1, mk(OP_EQ, 64'd9, 64'd8), 3'd2);
      sample();
      check_val("t6.ready1", 64'(req_ready_o), 64'd1);
      next_cycle();
      req_valid_i = 2'b00;
      sample();
      check_res("t6.eq", 64'd0, 1'b1, 1'b1, 3'd6);
      next_cycle();
      sample();
      check_res("t6.ne", 64'd0, 1'b0, 1'b0, 3'd2);
      check_val("t6.err", 64'(err_o), 64'd0);
      next_cycle();
      sample();
      check_val("t6.err2", 64'(err_o), 64'd0);

      // 5) ALU drops its valid for an ADD: err_o sticks until reset
      do_reset();
      res_ready_i = 1'b1;
      set_port(0, 1'b1, mk(OP_ADD, 64'd1, 64'd2), 3'd1);
      drop_valid = 1'b1;
      sample();
      check_val("t5.ready", 64'(req_ready_o), 64'd1);
      next_cycle();
      req_valid_i = 2'b00;
      drop_valid  = 1'b0;
      sample();
      check_val("t5.err0", 64'(err_o), 64'd0);
      next_cycle();
      sample();
      check_val("t5.err1", 64'(err_o), 64'd1);
      check_res("t5", 64'd3, 1'b0, 1'b0, 3'd1);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         sample();
         check_val("t5.sticky", 64'(err_o), 64'd1);
      end
      next_cycle();
      rst_i = 1'b1;
      next_cycle();
      rst_i = 1'b0;
      sample();
      check_val("t5.cleared", 64'(err_o), 64'd0);

      // Reset mid-operation drops the in-flight result.
      set_port(0, 1'b1, mk(OP_ADD, 64'd4, 64'd4), 3'd5);
      sample();
      check_val("rm.ready", 64'(req_ready_o), 64'd1);
      next_cycle();
      req_valid_i = 2'b00;
      rst_i       = 1'b1;
      next_cycle();
      rst_i = 1'b0;
      sample();
      check_val("rm.res0", 64'(res_valid_o), 64'd0);
      next_cycle();
      sample();
      check_val("rm.res1", 64'(res_valid_o), 64'd0);
      check_val("rm.err",  64'(err_o),       64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
